// File: rtl/lcu32_eq_and_unit.sv
// Compare and arithmetic primitives for the fetch/execute datapaths: a 32-bit two-level
// carry-lookahead adder, an equality comparator and a bitwise AND, each with a registered copy.
module lcu32_eq_and_unit #(
    parameter int EQ_WIDTH  = 6,
    parameter int AND_WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [0:31]          inA,
    input  logic [0:31]          inB,
    input  logic                 c0,
    output logic [0:31]          sum,
    output logic                 cout,
    output logic                 ovf,
    input  logic [EQ_WIDTH-1:0]  eq_a,
    input  logic [EQ_WIDTH-1:0]  eq_b,
    output logic                 eq_out,
    input  logic [AND_WIDTH-1:0] and_a,
    input  logic [AND_WIDTH-1:0] and_b,
    output logic [AND_WIDTH-1:0] and_out,
    output logic [0:31]          sum_q,
    output logic                 cout_q,
    output logic                 ovf_q,
    output logic                 eq_q,
    output logic [AND_WIDTH-1:0] and_q
);

    // Second-level lookahead; index 0 is the least-significant group, c[8] is the final carry.
    // Each carry is a flat sum of products, so no carry ripples from one group to the next.
    function automatic logic [8:0] lookahead8(input logic [7:0] gg, input logic [7:0] gp,
                                              input logic cin);
        logic [8:0] c;
        logic       term;
        c = 9'b0;
        for (int n = 0; n <= 8; n++) begin
            term = cin;
            for (int l = 0; l < n; l++) term = term & gp[l[2:0]];
            c[n[3:0]] = term;
            for (int m = 0; m < n; m++) begin
                term = gg[m[2:0]];
                for (int l = m + 1; l < n; l++) term = term & gp[l[2:0]];
                c[n[3:0]] = c[n[3:0]] | term;
            end
        end
        return c;
    endfunction

    logic [0:31] w_g;
    logic [0:31] w_p;
    logic [0:31] w_c;
    logic [7:0]  w_grp_g;
    logic [7:0]  w_grp_p;
    logic [8:0]  w_grp_c;

    assign w_g = inA & inB;
    assign w_p = inA ^ inB;

    for (genvar n = 0; n < 8; n++) begin : g_group
        localparam int B = 4 * (7 - n);
        logic [3:0] w_gl;
        logic [3:0] w_pl;
        logic       w_cin;

        assign w_gl  = {w_g[B], w_g[B+1], w_g[B+2], w_g[B+3]};
        assign w_pl  = {w_p[B], w_p[B+1], w_p[B+2], w_p[B+3]};
        assign w_cin = w_grp_c[n];

        assign w_c[B+3] = w_cin;
        assign w_c[B+2] = w_gl[0] | (w_pl[0] & w_cin);
        assign w_c[B+1] = w_gl[1] | (w_pl[1] & w_gl[0]) | (w_pl[1] & w_pl[0] & w_cin);
        assign w_c[B]   = w_gl[2] | (w_pl[2] & w_gl[1]) | (w_pl[2] & w_pl[1] & w_gl[0])
                        | (w_pl[2] & w_pl[1] & w_pl[0] & w_cin);

        assign w_grp_g[n] = w_gl[3] | (w_pl[3] & w_gl[2]) | (w_pl[3] & w_pl[2] & w_gl[1])
                          | (w_pl[3] & w_pl[2] & w_pl[1] & w_gl[0]);
        assign w_grp_p[n] = &w_pl;
    end

    assign w_grp_c = lookahead8(w_grp_g, w_grp_p, c0);

    assign sum     = w_p ^ w_c;
    assign cout    = w_grp_c[8];
    assign ovf     = w_c[0] ^ w_grp_c[8];
    assign eq_out  = (eq_a == eq_b);
    assign and_out = and_a & and_b;

    logic [0:31]          r_sum;
    logic                 r_cout;
    logic                 r_ovf;
    logic                 r_eq;
    logic [AND_WIDTH-1:0] r_and;

    // Pipeline copies of every result: clear on reset, load on enable, otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sum  <= 32'h0000_0000;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_eq   <= 1'b0;
            r_and  <= '0;
        end else if (en) begin
            r_sum  <= sum;
            r_cout <= cout;
            r_ovf  <= ovf;
            r_eq   <= eq_out;
            r_and  <= and_out;
        end else begin
            r_sum  <= r_sum;
            r_cout <= r_cout;
            r_ovf  <= r_ovf;
            r_eq   <= r_eq;
            r_and  <= r_and;
        end
    end

    assign sum_q  = r_sum;
    assign cout_q = r_cout;
    assign ovf_q  = r_ovf;
    assign eq_q   = r_eq;
    assign and_q  = r_and;

endmodule

// File: tb/tb_lcu32_eq_and_unit.sv
// Directed-vector bench for lcu32_eq_and_unit: table of adder/compare/AND cases, register
// control sequences, and random adder vectors against an arithmetic model.
module tb_lcu32_eq_and_unit;

    logic        clk = 1'b0;
    logic        reset, en, c0;
    logic [0:31] inA, inB, sum, sum_q;
    logic        cout, ovf, cout_q, ovf_q;
    logic [5:0]  eq_a, eq_b;
    logic        eq_out, eq_q;
    logic [0:0]  and_a, and_b, and_out, and_q;

    int n_checks = 0;
    int n_pass   = 0;

    lcu32_eq_and_unit #(.EQ_WIDTH(6), .AND_WIDTH(1)) dut (
        .clk(clk), .reset(reset), .en(en),
        .inA(inA), .inB(inB), .c0(c0),
        .sum(sum), .cout(cout), .ovf(ovf),
        .eq_a(eq_a), .eq_b(eq_b), .eq_out(eq_out),
        .and_a(and_a), .and_b(and_b), .and_out(and_out),
        .sum_q(sum_q), .cout_q(cout_q), .ovf_q(ovf_q), .eq_q(eq_q), .and_q(and_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a, b;
        logic        ci;
        logic [31:0] s;
        logic        co, ov;
        logic [5:0]  ea, eb;
        logic        eq;
        logic        aa, ab, an;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{32'h0000_0000, 32'h0000_0004, 1'b0, 32'h0000_0004, 1'b0, 1'b0, 6'h02, 6'h02, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 6'h02, 6'h03, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 6'h12, 6'h13, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 6'h3F, 6'h3F, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 6'h20, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 6'h01, 6'h00, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[6] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 32'hACF1_3569, 1'b0, 1'b0, 6'h00, 6'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 6'h15, 6'h2A, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[8] = '{32'h0FFF_FFFF, 32'h0000_0001, 1'b0, 32'h1000_0000, 1'b0, 1'b0, 6'h2A, 6'h2A, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[9] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 6'h07, 6'h07, 1'b1, 1'b1, 1'b1, 1'b1};

        // Reset with enable high and live inputs that would otherwise load nonzero values.
        reset = 1'b1; en = 1'b1; c0 = 1'b1;
        inA = 32'hFFFF_FFFF; inB = 32'h0000_0001;
        eq_a = 6'h05; eq_b = 6'h05; and_a = 1'b1; and_b = 1'b1;
        tick();
        check("reset_sum_q",  64'(sum_q),  64'h0);
        check("reset_cout_q", 64'(cout_q), 64'h0);
        check("reset_ovf_q",  64'(ovf_q),  64'h0);
        check("reset_eq_q",   64'(eq_q),   64'h0);
        check("reset_and_q",  64'(and_q),  64'h0);
        check("reset_sum_live", 64'(sum), 64'h0000_0001);

        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            inA = vecs[i].a; inB = vecs[i].b; c0 = vecs[i].ci;
            eq_a = vecs[i].ea; eq_b = vecs[i].eb; and_a = vecs[i].aa; and_b = vecs[i].ab;
            en = 1'b1;
            #1;
            check($sformatf("v%0d_sum", i),  64'(sum),     64'(vecs[i].s));
            check($sformatf("v%0d_cout", i), 64'(cout),    64'(vecs[i].co));
            check($sformatf("v%0d_ovf", i),  64'(ovf),     64'(vecs[i].ov));
            check($sformatf("v%0d_eq", i),   64'(eq_out),  64'(vecs[i].eq));
            check($sformatf("v%0d_and", i),  64'(and_out), 64'(vecs[i].an));
            tick();
            check($sformatf("v%0d_sum_q", i),  64'(sum_q),  64'(vecs[i].s));
            check($sformatf("v%0d_cout_q", i), 64'(cout_q), 64'(vecs[i].co));
            check($sformatf("v%0d_ovf_q", i),  64'(ovf_q),  64'(vecs[i].ov));
            check($sformatf("v%0d_eq_q", i),   64'(eq_q),   64'(vecs[i].eq));
            check($sformatf("v%0d_and_q", i),  64'(and_q),  64'(vecs[i].an));
        end

        // Hold: load a known value, then drop enable and change every input.
        inA = 32'h0000_0000; inB = 32'h0000_0004; c0 = 1'b0;
        eq_a = 6'h02; eq_b = 6'h02; and_a = 1'b1; and_b = 1'b1; en = 1'b1;
        tick();
        en = 1'b0;
        inA = 32'h7FFF_FFFF; inB = 32'h0000_0001; eq_b = 6'h03; and_b = 1'b0;
        tick();
        tick();
        check("hold_sum_q",  64'(sum_q),  64'h0000_0004);
        check("hold_ovf_q",  64'(ovf_q),  64'h0);
        check("hold_eq_q",   64'(eq_q),   64'h1);
        check("hold_and_q",  64'(and_q),  64'h1);
        check("hold_sum_live", 64'(sum), 64'h8000_0000);

        // Reset mid-stream with enable high; combinational path keeps tracking.
        inA = 32'h0000_0010; inB = 32'h0000_0020; eq_b = 6'h02; and_b = 1'b1;
        en = 1'b1; reset = 1'b1;
        tick();
        check("mid_reset_sum_q", 64'(sum_q), 64'h0);
        check("mid_reset_eq_q",  64'(eq_q),  64'h0);
        check("mid_reset_and_q", 64'(and_q), 64'h0);
        check("mid_reset_sum",   64'(sum),   64'h0000_0030);

        // Release reset without enable, then reload with enable.
        reset = 1'b0; en = 1'b0;
        tick();
        check("post_reset_hold_sum_q", 64'(sum_q), 64'h0);
        en = 1'b1;
        tick();
        check("reload_sum_q", 64'(sum_q), 64'h0000_0030);
        check("reload_eq_q",  64'(eq_q),  64'h1);
        check("reload_and_q", 64'(and_q), 64'h1);

        // Random adder vectors against arithmetic model.
        for (int k = 0; k < 2000; k++) begin
            logic [31:0] ra, rb;
            logic        rc;
            logic [32:0] full;
            logic        exp_ovf;
            ra = $urandom; rb = $urandom; rc = 1'($urandom_range(1, 0));
            if (k % 4 == 0) rb = ~ra;
            full = {1'b0, ra} + {1'b0, rb} + {32'h0, rc};
            exp_ovf = (ra[31] == rb[31]) && (full[31] != ra[31]);
            inA = ra; inB = rb; c0 = rc;
            #1;
            check($sformatf("rand%0d", k), {31'h0, cout, ovf, 32'(sum)},
                  {31'h0, full[32], exp_ovf, full[31:0]});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
